alu_instr_sequencer: RTL and testbench
======================================

// Module: alu_instr_sequencer
// PURPOSE
//  Parametrised control sequencer for the Phase-1 datapath. It generates the T0..T6
//  control strobes (Rin/Rout one-hots, PC/MAR/MDR/IR/Y/Z/HI/LO enables, ALUop) for every
//  ALU-class instruction. This replaces hand-written per-instruction strobe tables in the benches.
//  It sits beside the datapath, reads back the IR output and adds a memory-ready wait state plus a start/done handshake.
// PARAMETERS
//  NUM_REGS   16  general registers; width of Rin/Rout one-hots
//  REG_IDX_W  4   IR register-field width; NUM_REGS must equal 2**REG_IDX_W
//  ALUOP_W    4   ALUop width; encodings from package (ALU_SUB = 4)
//  OPCODE_W   5   IR opcode width, IR[31:27]
// PORTS
//  clock      in   1         system clock, all state on rising edge
//  clear_n    in   1         asynchronous active-low reset
//  start      in   1         request to execute one instruction; sampled in IDLE or final T-state
//  ir         in   32        datapath IR output; opcode IR[31:27], Ra[26:23], Rb[22:19], Rc[18:15]
//  mem_ready  in   1         memory data valid this cycle (T1 fetch)
//  Rin        out  NUM_REGS  one-hot register load
//  Rout       out  NUM_REGS  one-hot register drive onto bus
//  PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout     out 1  datapath strobes
//  Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin                     out 1  Z/HI/LO strobes
//  ALUop      out  ALUOP_W   ALU operation, non-zero only in T4
//  busy       out  1         high in every state except IDLE
//  done       out  1         one-cycle pulse in the last T-state of a legal instruction
//  illegal    out  1         one-cycle pulse in T3 when the opcode is not ALU-class
// BEHAVIOUR
//  - Moore outputs decoded from the state register and ir. All outputs are 0 in IDLE and while clear_n=0.
//  - States: IDLE, T0, T1, T2, T3, T4, T5, T6. clear_n low sends the state to IDLE immediately, including mid-instruction.
//  - IDLE: start=1 -> T0 next edge.
//  - T0: PCout, MARin, IncPC, Zlowin -> T1.
//  - T1: Zlowout, Read, MDRin held every cycle. PCin only in the cycle with mem_ready=1, so PC is written exactly once.
//    Stays in T1 while mem_ready=0; the wait is unbounded. Goes to T2 when mem_ready=1.
//  - T2: MDRout, IRin -> T3. ir is valid from T3 onward.
//  - T3: non-ALU opcode -> illegal=1, no strobes, next IDLE (no register, HI or LO written).
//    Otherwise: Rout[Rb] + Yin for binary, immediate and unary classes. MUL/DIV use Rout[Ra] + Yin.
//  - T4 (ALUop = package map of opcode):
//    - three-reg: Rout[Rc], Zlowin
//    - immediate (ADDI/ANDI/ORI): Cout, Zlowin
//    - unary (NEG/NOT): Rout[Rb], Zlowin
//    - MUL/DIV: Rout[Rb], Zlowin, Zhighin
//  - T5: MUL/DIV -> Zlowout, LOin, then T6. Others -> Zlowout, Rin[Ra], done=1.
//  - T6 (MUL/DIV only): Zhighout, HIin, done=1.
//  - Final state (done=1): start=1 -> T0 back-to-back, no IDLE bubble; else IDLE. start is ignored elsewhere.
//  - Latency from start-sampled edge with mem_ready tied 1: ALU/imm/unary 6 cycles; MUL/DIV 7 cycles. Each low mem_ready cycle adds 1.
//  - Rin and Rout are each strictly one-hot or zero, and never share a bit. At most one bus driver per cycle.
//  - Rin, LOin and HIin are never asserted in the same cycle as illegal.
// STRUCTURE
//  - Package cpu_ctrl_pkg:
//    - opcode localparams: ADD=3, SUB=4, AND=5, OR=6, ROR=7, ROL=8, SHR=9, SHRA=10, SHL=11,
//      ADDI=12, ANDI=13, ORI=14, DIV=15, MUL=16, NEG=17, NOT=18
//    - ALU_* encodings; state encodings
//    - function opcode_class() returning BIN/IMM/UN/MULDIV/ILLEGAL
//  - One sub-module: reg_field_onehot (REG_IDX_W index -> NUM_REGS one-hot with enable), instantiated for Rin and Rout.
// TESTING
//  - sub R2,R5,R6 (ir=32'h212B0000), mem_ready=1, start one cycle:
//    T3 Rout=16'h0020 Yin; T4 Rout=16'h0040 ALUop=4 Zlowin; T5 Rin=16'h0004 done. With datapath R5=0x34, R6=0x45 -> R2=0xFFFFFFEF.
//  - Same instruction, mem_ready low 3 cycles in T1: T1 lasts 4 cycles, PCin high exactly once, done 9 cycles after start.
//  - mul R3,R4 (opcode 16): T4 Zhighin&Zlowin; T5 LOin; T6 HIin, done; Rin stays 0 throughout.
//  - start held high across two add instructions: second T0 immediately follows first T5, busy never drops.
//  - opcode 31 in ir: illegal pulses in T3, state IDLE next, Rin/LOin/HIin never asserted.
//  - clear_n pulled low during T4: all outputs 0 asynchronously, IDLE after release; next start runs a clean sequence.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the ALU-class instruction sequencer: opcodes, ALU ops,
// T-state encoding, IR field layout and opcode classification helpers.
package cpu_ctrl_pkg;

  localparam int unsigned OPCODE_WIDTH  = 5;
  localparam int unsigned ALUOP_WIDTH   = 4;
  localparam int unsigned REG_IDX_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 5'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 5'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_ROR  = 5'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_ROL  = 5'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR  = 5'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_SHRA = 5'd10;
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL  = 5'd11;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'd12;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = 5'd13;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI  = 5'd14;
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV  = 5'd15;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = 5'd16;
  localparam logic [OPCODE_WIDTH-1:0] OP_NEG  = 5'd17;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT  = 5'd18;

  localparam logic [ALUOP_WIDTH-1:0] ALU_NOP  = 4'd0;
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 4'd3;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 4'd4;
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = 4'd5;
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = 4'd6;
  localparam logic [ALUOP_WIDTH-1:0] ALU_ROR  = 4'd7;
  localparam logic [ALUOP_WIDTH-1:0] ALU_ROL  = 4'd8;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SHR  = 4'd9;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SHRA = 4'd10;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SHL  = 4'd11;
  localparam logic [ALUOP_WIDTH-1:0] ALU_NEG  = 4'd12;
  localparam logic [ALUOP_WIDTH-1:0] ALU_NOT  = 4'd13;
  localparam logic [ALUOP_WIDTH-1:0] ALU_DIV  = 4'd14;
  localparam logic [ALUOP_WIDTH-1:0] ALU_MUL  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_T6   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_BIN,
    CLS_IMM,
    CLS_UN,
    CLS_MULDIV,
    CLS_ILLEGAL
  } op_class_t;

  // IR layout as seen on the datapath IR output
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [REG_IDX_WIDTH-1:0] ra;
    logic [REG_IDX_WIDTH-1:0] rb;
    logic [REG_IDX_WIDTH-1:0] rc;
    logic [14:0]              imm;
  } ir_fields_t;

  function automatic op_class_t opcode_class(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:    return CLS_BIN;
      OP_ADDI, OP_ANDI, OP_ORI:           return CLS_IMM;
      OP_NEG, OP_NOT:                     return CLS_UN;
      OP_MUL, OP_DIV:                     return CLS_MULDIV;
      default:                            return CLS_ILLEGAL;
    endcase
  endfunction

  // Immediate forms share the ALU operation of their register forms
  function automatic logic [ALUOP_WIDTH-1:0] alu_map(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_SHR:          return ALU_SHR;
      OP_SHRA:         return ALU_SHRA;
      OP_SHL:          return ALU_SHL;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      OP_DIV:          return ALU_DIV;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Handshake and strobe bundle between the sequencer and the Phase-1 datapath.
// master = datapath/requester side, slave = sequencer side.
interface alu_instr_sequencer_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ALUOP_W  = 4
);
  logic                start;
  logic [31:0]         ir;
  logic                mem_ready;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout;
  logic Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
  logic [ALUOP_W-1:0]  ALUop;
  logic                busy;
  logic                done;
  logic                illegal;

  modport master (
    output start, ir, mem_ready,
    input  Rin, Rout, PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout,
    input  Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin, ALUop, busy, done, illegal
  );

  modport slave (
    input  start, ir, mem_ready,
    output Rin, Rout, PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout,
    output Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin, ALUop, busy, done, illegal
  );
endinterface

// File: rtl/reg_field_onehot.sv
// Decodes an IR register field into a one-hot register select, gated by an enable.
module reg_field_onehot #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned REG_IDX_W = 4
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot_c
);
  always_comb begin
    onehot_c = '0;
    if (en) onehot_c[idx] = 1'b1;
  end
endmodule

// File: rtl/alu_instr_sequencer.sv
// T0..T6 control sequencer for ALU-class instructions on the Phase-1 datapath,
// with a memory-ready wait in T1 and a start/done handshake.
module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned REG_IDX_W = REG_IDX_WIDTH,
  parameter int unsigned ALUOP_W   = ALUOP_WIDTH,
  parameter int unsigned OPCODE_W  = OPCODE_WIDTH
) (
  input logic                  clock,
  input logic                  clear_n,
  alu_instr_sequencer_if.slave bus
);

  state_t               state;
  state_t               state_next;
  ir_fields_t           ir_f;
  logic [OPCODE_W-1:0]  opcode;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic [REG_IDX_W-1:0] rc;
  logic [REG_IDX_W-1:0] rout_idx;
  op_class_t            op_class;
  logic                 rin_en;
  logic                 rout_en;
  logic                 unused_ir_bits;

  assign ir_f           = bus.ir;
  assign opcode         = OPCODE_W'(ir_f.opcode);
  assign ra             = REG_IDX_W'(ir_f.ra);
  assign rb             = REG_IDX_W'(ir_f.rb);
  assign rc             = REG_IDX_W'(ir_f.rc);
  assign unused_ir_bits = ^ir_f.imm;
  assign op_class       = opcode_class(OPCODE_WIDTH'(opcode));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Moore strobe decode; PCin alone also looks at mem_ready so PC is written once per fetch
  always_comb begin
    state_next   = state;
    bus.PCin     = 1'b0;
    bus.PCout    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Cout     = 1'b0;
    bus.Zlowin   = 1'b0;
    bus.Zhighin  = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.ALUop    = '0;
    bus.busy     = (state != ST_IDLE);
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    rin_en       = 1'b0;
    rout_en      = 1'b0;
    rout_idx     = rb;

    case (state)
      ST_IDLE: begin
        if (bus.start) state_next = ST_T0;
      end
      ST_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
        state_next = ST_T1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (bus.mem_ready) begin
          bus.PCin   = 1'b1;
          state_next = ST_T2;
        end
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_next = ST_T3;
      end
      ST_T3: begin
        if (op_class == CLS_ILLEGAL) begin
          bus.illegal = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          rout_en    = 1'b1;
          rout_idx   = (op_class == CLS_MULDIV) ? ra : rb;
          bus.Yin    = 1'b1;
          state_next = ST_T4;
        end
      end
      ST_T4: begin
        bus.ALUop  = ALUOP_W'(alu_map(OPCODE_WIDTH'(opcode)));
        bus.Zlowin = 1'b1;
        case (op_class)
          CLS_BIN: begin
            rout_en  = 1'b1;
            rout_idx = rc;
          end
          CLS_IMM: bus.Cout = 1'b1;
          CLS_UN:  rout_en  = 1'b1;
          CLS_MULDIV: begin
            rout_en     = 1'b1;
            bus.Zhighin = 1'b1;
          end
          default: ;
        endcase
        state_next = ST_T5;
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (op_class == CLS_MULDIV) begin
          bus.LOin   = 1'b1;
          state_next = ST_T6;
        end else begin
          rin_en     = 1'b1;
          bus.done   = 1'b1;
          state_next = bus.start ? ST_T0 : ST_IDLE;
        end
      end
      ST_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
        state_next   = bus.start ? ST_T0 : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  reg_field_onehot #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W)
  ) u_rin_dec (
    .idx      (ra),
    .en       (rin_en),
    .onehot_c (bus.Rin)
  );

  reg_field_onehot #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W)
  ) u_rout_dec (
    .idx      (rout_idx),
    .en       (rout_en),
    .onehot_c (bus.Rout)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: directed instructions push per-cycle
// expected strobe snapshots; a negedge monitor pops and compares them.
module tb_alu_instr_sequencer;

  localparam logic [15:0] S_PCIN     = 16'h8000;
  localparam logic [15:0] S_PCOUT    = 16'h4000;
  localparam logic [15:0] S_INCPC    = 16'h2000;
  localparam logic [15:0] S_MARIN    = 16'h1000;
  localparam logic [15:0] S_READ     = 16'h0800;
  localparam logic [15:0] S_MDRIN    = 16'h0400;
  localparam logic [15:0] S_MDROUT   = 16'h0200;
  localparam logic [15:0] S_IRIN     = 16'h0100;
  localparam logic [15:0] S_YIN      = 16'h0080;
  localparam logic [15:0] S_COUT     = 16'h0040;
  localparam logic [15:0] S_ZLOWIN   = 16'h0020;
  localparam logic [15:0] S_ZHIGHIN  = 16'h0010;
  localparam logic [15:0] S_ZLOWOUT  = 16'h0008;
  localparam logic [15:0] S_ZHIGHOUT = 16'h0004;
  localparam logic [15:0] S_LOIN     = 16'h0002;
  localparam logic [15:0] S_HIIN     = 16'h0001;

  localparam logic [31:0] SUB_IR  = 32'h212B0000;                        // sub R2,R5,R6
  localparam logic [31:0] MUL_IR  = {5'd16, 4'd3, 4'd4, 4'd0, 15'd0};    // mul R3,R4
  localparam logic [31:0] ADDI_IR = {5'd12, 4'd1, 4'd2, 4'd0, 15'd5};    // addi R1,R2,5
  localparam logic [31:0] NEG_IR  = {5'd17, 4'd4, 4'd5, 4'd0, 15'd0};    // neg R4,R5
  localparam logic [31:0] ADDA_IR = {5'd3, 4'd1, 4'd2, 4'd3, 15'd0};     // add R1,R2,R3
  localparam logic [31:0] ADDB_IR = {5'd3, 4'd7, 4'd8, 4'd9, 15'd0};     // add R7,R8,R9
  localparam logic [31:0] BAD_IR  = {5'd31, 27'd0};

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [15:0] strb;
    logic [3:0]  alu;
    logic        busy;
    logic        done;
    logic        illegal;
  } snap_t;

  logic   clock;
  logic   clear_n;
  int     checks = 0;
  int     errors = 0;
  int     lat_cnt = 0;
  int     lat_exp;
  bit     active = 1'b0;
  snap_t  exp_q[$];
  string  name_q[$];
  int     lat_q[$];
  snap_t  mon_act;
  snap_t  mon_exp;
  string  mon_name;

  alu_instr_sequencer_if #(.NUM_REGS(16), .ALUOP_W(4)) bus ();

  alu_instr_sequencer #(
    .NUM_REGS  (16),
    .REG_IDX_W (4),
    .ALUOP_W   (4),
    .OPCODE_W  (5)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic snap_t sample();
    return {bus.Rin, bus.Rout,
            bus.PCin, bus.PCout, bus.IncPC, bus.MARin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Cout, bus.Zlowin, bus.Zhighin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin,
            bus.ALUop, bus.busy, bus.done, bus.illegal};
  endfunction

  task automatic check_snap(input string nm, input snap_t act, input snap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rin=%h rout=%h strb=%h alu=%h busy=%b done=%b ill=%b, want rin=%h rout=%h strb=%h alu=%h busy=%b done=%b ill=%b",
               nm, act.rin, act.rout, act.strb, act.alu, act.busy, act.done, act.illegal,
               exp.rin, exp.rout, exp.strb, exp.alu, exp.busy, exp.done, exp.illegal);
    end
  endtask

  // Monitor: once an instruction starts, every cycle must match the next queued snapshot
  always @(negedge clock) begin
    mon_act = sample();
    if (exp_q.size() != 0 && (active || bus.busy)) begin
      active   = 1'b1;
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      check_snap(mon_name, mon_act, mon_exp);
      if (exp_q.size() == 0) active = 1'b0;
    end else if (exp_q.size() == 0) begin
      check_snap("idle", mon_act, '0);
    end
    if (!bus.busy) begin
      lat_cnt = 0;
    end else begin
      lat_cnt++;
      if (bus.done) begin
        checks++;
        lat_exp = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
        if (lat_cnt != lat_exp) begin
          errors++;
          $display("FAIL latency: got %0d cycles, want %0d", lat_cnt, lat_exp);
        end
        lat_cnt = 0;
      end else if (bus.illegal) begin
        lat_cnt = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input string nm, input logic [15:0] rin, input logic [15:0] rout,
                      input logic [15:0] strb, input logic [3:0] alu, input logic dn, input logic il);
    exp_q.push_back({rin, rout, strb, alu, 1'b1, dn, il});
    name_q.push_back(nm);
  endtask

  task automatic push_fetch(input string nm, input int waits);
    push({nm, ".T0"}, 16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++)
      push({nm, ".T1wait"}, 16'h0, 16'h0, S_ZLOWOUT | S_READ | S_MDRIN, 4'd0, 1'b0, 1'b0);
    push({nm, ".T1"}, 16'h0, 16'h0, S_ZLOWOUT | S_READ | S_MDRIN | S_PCIN, 4'd0, 1'b0, 1'b0);
    push({nm, ".T2"}, 16'h0, 16'h0, S_MDROUT | S_IRIN, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic push_sub_tail(input string nm);
    push({nm, ".T3"}, 16'h0,    16'h0020, S_YIN,     4'd0, 1'b0, 1'b0);
    push({nm, ".T4"}, 16'h0,    16'h0040, S_ZLOWIN,  4'd4, 1'b0, 1'b0);
    push({nm, ".T5"}, 16'h0004, 16'h0,    S_ZLOWOUT, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || lat_q.size() != 0) && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d snapshots and %0d latencies outstanding, want 0", exp_q.size(), lat_q.size());
      exp_q.delete();
      name_q.delete();
      lat_q.delete();
      active = 1'b0;
    end
    cyc(2);
  endtask

  task automatic run_one(input logic [31:0] instr, input int waits);
    bus.ir    = instr;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    if (waits > 0) begin
      bus.mem_ready = 1'b0;
      cyc(waits + 1);
      bus.mem_ready = 1'b1;
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run by 100us, want end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_n       = 1'b0;
    bus.start     = 1'b0;
    bus.mem_ready = 1'b1;
    bus.ir        = 32'h0;
    cyc(3);
    clear_n = 1'b1;
    cyc(2);

    // sub R2,R5,R6 with memory always ready
    push_fetch("sub", 0);
    push_sub_tail("sub");
    lat_q.push_back(6);
    run_one(SUB_IR, 0);

    // same instruction with three wait cycles in T1
    push_fetch("subw", 3);
    push_sub_tail("subw");
    lat_q.push_back(9);
    run_one(SUB_IR, 3);

    // mul R3,R4: LO then HI, no register write
    push_fetch("mul", 0);
    push("mul.T3", 16'h0, 16'h0008, S_YIN,                4'd0,  1'b0, 1'b0);
    push("mul.T4", 16'h0, 16'h0010, S_ZLOWIN | S_ZHIGHIN, 4'd15, 1'b0, 1'b0);
    push("mul.T5", 16'h0, 16'h0,    S_ZLOWOUT | S_LOIN,   4'd0,  1'b0, 1'b0);
    push("mul.T6", 16'h0, 16'h0,    S_ZHIGHOUT | S_HIIN,  4'd0,  1'b1, 1'b0);
    lat_q.push_back(7);
    run_one(MUL_IR, 0);

    // addi R1,R2: constant via Cout
    push_fetch("addi", 0);
    push("addi.T3", 16'h0,    16'h0004, S_YIN,             4'd0, 1'b0, 1'b0);
    push("addi.T4", 16'h0,    16'h0,    S_COUT | S_ZLOWIN, 4'd3, 1'b0, 1'b0);
    push("addi.T5", 16'h0002, 16'h0,    S_ZLOWOUT,         4'd0, 1'b1, 1'b0);
    lat_q.push_back(6);
    run_one(ADDI_IR, 0);

    // neg R4,R5: Rb driven in both T3 and T4
    push_fetch("neg", 0);
    push("neg.T3", 16'h0,    16'h0020, S_YIN,     4'd0,  1'b0, 1'b0);
    push("neg.T4", 16'h0,    16'h0020, S_ZLOWIN,  4'd12, 1'b0, 1'b0);
    push("neg.T5", 16'h0010, 16'h0,    S_ZLOWOUT, 4'd0,  1'b1, 1'b0);
    lat_q.push_back(6);
    run_one(NEG_IR, 0);

    // start held high: second T0 follows first T5 with no idle bubble
    push_fetch("adda", 0);
    push("adda.T3", 16'h0,    16'h0004, S_YIN,     4'd0, 1'b0, 1'b0);
    push("adda.T4", 16'h0,    16'h0008, S_ZLOWIN,  4'd3, 1'b0, 1'b0);
    push("adda.T5", 16'h0002, 16'h0,    S_ZLOWOUT, 4'd0, 1'b1, 1'b0);
    push_fetch("addb", 0);
    push("addb.T3", 16'h0,    16'h0100, S_YIN,     4'd0, 1'b0, 1'b0);
    push("addb.T4", 16'h0,    16'h0200, S_ZLOWIN,  4'd3, 1'b0, 1'b0);
    push("addb.T5", 16'h0080, 16'h0,    S_ZLOWOUT, 4'd0, 1'b1, 1'b0);
    lat_q.push_back(6);
    lat_q.push_back(6);
    bus.ir    = ADDA_IR;
    bus.start = 1'b1;
    cyc(7);
    bus.start = 1'b0;
    bus.ir    = ADDB_IR;
    drain();

    // illegal opcode: pulse in T3 with no strobes, then idle
    push_fetch("ill", 0);
    push("ill.T3", 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1);
    run_one(BAD_IR, 0);

    // asynchronous clear during T4, then a clean rerun
    push_fetch("clr", 0);
    push("clr.T3", 16'h0, 16'h0020, S_YIN, 4'd0, 1'b0, 1'b0);
    bus.ir    = SUB_IR;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(4);
    #1;
    clear_n = 1'b0;
    #1;
    check_snap("clr.async", sample(), '0);
    cyc(2);
    clear_n = 1'b1;
    drain();

    push_fetch("rerun", 0);
    push_sub_tail("rerun");
    lat_q.push_back(6);
    run_one(SUB_IR, 0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
